// File: rtl/instr_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl_if
// Description : Host loader bundle for instr_mem_ctrl (beats, clear, run request).
// Revision    : 1.0
// ============================================================================
interface instr_mem_ctrl_if;
    logic [31:0] host_wdata;
    logic        host_valid;
    logic        host_ready;
    logic        host_clear;
    logic        run_req;

    modport master (
        output host_wdata,
        output host_valid,
        output host_clear,
        output run_req,
        input  host_ready
    );

    modport slave (
        input  host_wdata,
        input  host_valid,
        input  host_clear,
        input  run_req,
        output host_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl
// Description : Arbitrates the instruction BRAM port between the host beat
//               packer and the sequence decoder. Optional: LOAD_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
module instr_mem_ctrl #(
    parameter int ADDR_SIZE = 15
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    instr_mem_ctrl_if.slave           host,
    input  wire logic [ADDR_SIZE-1:0] dec_mem_addr,
    output logic                      run,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [ADDR_SIZE-1:0]      bram_addr,
    output logic [119:0]              bram_wdata,
    output logic [ADDR_SIZE:0]        prog_len,
    output logic [1:0]                ctrl_state,
    output logic [2:0]                err_flags
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [31:0]               checksum
`endif
);

    localparam logic [ADDR_SIZE:0] c_depth = {1'b1, {ADDR_SIZE{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ARM   = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_beat_cnt;
    logic [95:0]            r_pack;
    logic [ADDR_SIZE-1:0]   r_wr_ptr;
    logic [ADDR_SIZE:0]     r_prog_len;
    logic [2:0]             r_err;
    logic                   r_run, r_bram_en, r_bram_we;
    logic [ADDR_SIZE-1:0]   r_bram_addr;
    logic [119:0]           r_bram_wdata;

    logic                   w_ready, w_accept, w_clear, w_commit, w_drop_beats;
    logic [2:0]             w_err_set;
    logic                   w_run_nxt, w_en_nxt, w_we_nxt;
    logic [ADDR_SIZE-1:0]   w_addr_nxt;
    logic [119:0]           w_wdata_nxt;
    logic [119:0]           w_word;
    logic                   w_unused_hi;

    assign w_ready         = (r_state == IDLE) && !host.run_req && reset;
    assign host.host_ready = w_ready;
    // A clear cycle swallows any beat offered alongside it.
    assign w_accept        = host.host_valid && w_ready && !host.host_clear;
    assign w_word          = {host.host_wdata[23:0], r_pack};
    assign w_unused_hi     = ^host.host_wdata[31:24];

    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = 1'b0;
        w_en_nxt     = 1'b0;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = '0;
        w_wdata_nxt  = '0;
        w_clear      = 1'b0;
        w_commit     = 1'b0;
        w_drop_beats = 1'b0;
        w_err_set    = 3'b000;
        case (r_state)
            IDLE: begin
                if (host.host_clear) begin
                    w_clear = 1'b1;
                end else if (host.run_req) begin
                    if (r_beat_cnt != 2'd0) begin
                        w_err_set[1] = 1'b1;
                        w_drop_beats = 1'b1;
                    end else if (r_prog_len == '0) begin
                        w_err_set[2] = 1'b1;
                    end else begin
                        // Prefetch word 0 so it is on the BRAM output when run rises.
                        w_state_nxt = ARM;
                        w_en_nxt    = 1'b1;
                    end
                end else if (w_accept && (r_beat_cnt == 2'd3)) begin
                    if (r_prog_len == c_depth) begin
                        w_err_set[0] = 1'b1;
                    end else begin
                        w_state_nxt = WRITE;
                        w_en_nxt    = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = r_wr_ptr;
                        w_wdata_nxt = w_word;
                    end
                end
            end
            WRITE: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            ARM: begin
                w_state_nxt = RUN;
                w_run_nxt   = 1'b1;
                w_en_nxt    = 1'b1;
                w_addr_nxt  = dec_mem_addr;
            end
            RUN: begin
                if (host.run_req) begin
                    w_run_nxt  = 1'b1;
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = dec_mem_addr;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_beat_cnt   <= 2'd0;
            r_pack       <= '0;
            r_wr_ptr     <= '0;
            r_prog_len   <= '0;
            r_err        <= 3'b000;
            r_run        <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= w_run_nxt;
            r_bram_en    <= w_en_nxt;
            r_bram_we    <= w_we_nxt;
            r_bram_addr  <= w_addr_nxt;
            r_bram_wdata <= w_wdata_nxt;
            if (w_clear) begin
                r_wr_ptr   <= '0;
                r_prog_len <= '0;
                r_beat_cnt <= 2'd0;
                r_err      <= 3'b000;
            end else begin
                r_err <= r_err | w_err_set;
                if (w_drop_beats) begin
                    r_beat_cnt <= 2'd0;
                end else if (w_accept) begin
                    r_beat_cnt <= r_beat_cnt + 2'd1;
                    case (r_beat_cnt)
                        2'd0:    r_pack[31:0]  <= host.host_wdata;
                        2'd1:    r_pack[63:32] <= host.host_wdata;
                        2'd2:    r_pack[95:64] <= host.host_wdata;
                        default: ;
                    endcase
                end
                if (w_commit) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_prog_len != c_depth) begin
                        r_prog_len <= r_prog_len + 1'b1;
                    end
                end
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_clear) begin
            r_checksum <= '0;
        end else if (w_commit) begin
            r_checksum <= r_checksum + {8'h00, r_bram_wdata[119:96]} + r_bram_wdata[95:64]
                        + r_bram_wdata[63:32] + r_bram_wdata[31:0];
        end
    end

    assign checksum = r_checksum;
`endif

    assign run        = r_run;
    assign bram_en    = r_bram_en;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;
    assign prog_len   = r_prog_len;
    assign ctrl_state = r_state;
    assign err_flags  = r_err;

endmodule
`default_nettype wire
